// File: rtl/jellyvl_synctimer_core_ch.sv
// Multi-channel synchronised timer core: fractional-rate time counter with +/-1 phase nudges,
// per-channel compare triggers (one-shot or periodic) and rising-edge timestamp captures.
module jellyvl_synctimer_core_ch #(
  parameter int unsigned TIMER_WIDTH = 64,
  parameter int unsigned NUMERATOR   = 10,
  parameter int unsigned DENOMINATOR = 3,
  parameter int unsigned CHANNELS    = 4
) (
  input  logic                            reset,
  input  logic                            clk,
  input  logic [TIMER_WIDTH-1:0]          set_time,
  input  logic                            set_valid,
  input  logic                            adjust_sign,
  input  logic                            adjust_valid,
  output logic                            adjust_ready,
  output logic [TIMER_WIDTH-1:0]          current_time,
  input  logic [CHANNELS*TIMER_WIDTH-1:0] trig_time,
  input  logic [CHANNELS*TIMER_WIDTH-1:0] trig_period,
  input  logic [CHANNELS-1:0]             trig_valid,
  input  logic [CHANNELS-1:0]             trig_cancel,
  output logic [CHANNELS-1:0]             trig_armed,
  output logic [CHANNELS-1:0]             trig_pulse,
  input  logic [CHANNELS-1:0]             cap_in,
  output logic [CHANNELS*TIMER_WIDTH-1:0] cap_time,
  output logic [CHANNELS-1:0]             cap_valid
);

  localparam int unsigned AccW = $clog2(DENOMINATOR) + 1;
  localparam logic [AccW-1:0] FracAcc = AccW'(NUMERATOR % DENOMINATOR);
  localparam logic [AccW-1:0] DenAcc = AccW'(DENOMINATOR);
  localparam logic [TIMER_WIDTH-1:0] IntStep = TIMER_WIDTH'(NUMERATOR / DENOMINATOR);
  localparam logic [TIMER_WIDTH-1:0] One = TIMER_WIDTH'(1);
  localparam logic signed [TIMER_WIDTH-1:0] Zero = '0;

  if (NUMERATOR < DENOMINATOR || DENOMINATOR < 1) begin : g_bad_ratio
    $error("jellyvl_synctimer_core_ch: NUMERATOR must be >= DENOMINATOR >= 1");
  end

  logic [TIMER_WIDTH-1:0] time_q, time_d;
  logic [AccW-1:0]        acc_q, acc_d, acc_sum;
  logic                   carry;
  logic                   pend_q, pend_d;
  logic                   sign_q, sign_d;

  logic [CHANNELS-1:0][TIMER_WIDTH-1:0] target_q, target_d;
  logic [CHANNELS-1:0][TIMER_WIDTH-1:0] period_q, period_d;
  logic [CHANNELS-1:0][TIMER_WIDTH-1:0] cap_time_q, cap_time_d;
  logic [CHANNELS-1:0] armed_q, armed_d;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] cap_valid_q, cap_valid_d;
  logic [CHANNELS-1:0] fire;

  always_comb begin
    acc_sum = acc_q + FracAcc;
    carry   = (acc_sum >= DenAcc);
    acc_d   = carry ? acc_sum - DenAcc : acc_sum;
    time_d  = time_q + IntStep + TIMER_WIDTH'(carry);
    pend_d  = pend_q;
    sign_d  = sign_q;
    if (pend_q) begin
      time_d = sign_q ? time_d - One : time_d + One;
      pend_d = 1'b0;
    end else if (adjust_valid) begin
      pend_d = 1'b1;
      sign_d = adjust_sign;
    end
    // A load discards both a latched adjust and one handshaking this cycle.
    if (set_valid) begin
      time_d = set_time;
      acc_d  = '0;
      pend_d = 1'b0;
    end
  end

  always_comb begin
    target_d    = target_q;
    period_d    = period_q;
    armed_d     = armed_q;
    pulse_d     = '0;
    cap_time_d  = cap_time_q;
    cap_valid_d = '0;
    fire        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Signed difference keeps the compare correct across counter wrap.
      fire[i] = armed_q[i] & ($signed(time_q - target_q[i]) >= Zero);
      if (trig_cancel[i]) begin
        armed_d[i] = 1'b0;
      end else if (trig_valid[i]) begin
        target_d[i] = trig_time[i*TIMER_WIDTH +: TIMER_WIDTH];
        period_d[i] = trig_period[i*TIMER_WIDTH +: TIMER_WIDTH];
        armed_d[i]  = 1'b1;
      end else if (fire[i]) begin
        pulse_d[i] = 1'b1;
        if (period_q[i] == '0) begin
          armed_d[i] = 1'b0;
        end else begin
          target_d[i] = target_q[i] + period_q[i];
        end
      end
      cap_valid_d[i] = cap_in[i] & ~prev_q[i];
      if (cap_valid_d[i]) begin
        cap_time_d[i] = time_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q      <= '0;
      acc_q       <= '0;
      pend_q      <= 1'b0;
      sign_q      <= 1'b0;
      target_q    <= '0;
      period_q    <= '0;
      armed_q     <= '0;
      pulse_q     <= '0;
      cap_time_q  <= '0;
      cap_valid_q <= '0;
      prev_q      <= '1;
    end else begin
      time_q      <= time_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      sign_q      <= sign_d;
      target_q    <= target_d;
      period_q    <= period_d;
      armed_q     <= armed_d;
      pulse_q     <= pulse_d;
      cap_time_q  <= cap_time_d;
      cap_valid_q <= cap_valid_d;
      prev_q      <= cap_in;
    end
  end

  assign adjust_ready = ~pend_q;
  assign current_time = time_q;
  assign trig_armed   = armed_q;
  assign trig_pulse   = pulse_q;
  assign cap_time     = cap_time_q;
  assign cap_valid    = cap_valid_q;

endmodule

// File: doc/jellyvl_synctimer_core_ch.md
# jellyvl_synctimer_core_ch

Multi-channel synchronised timer core. It advances a TIMER_WIDTH time counter by exactly NUMERATOR/DENOMINATOR per clock using a fractional accumulator, and accepts ±1 phase nudges through a sign/valid/ready handshake from an external adjust unit. It adds CHANNELS one-shot/periodic compare triggers and CHANNELS rising-edge timestamp captures. It replaces the single-timer core as the timing hub feeding event generators and capture logic.

## Interface
- TIMER_WIDTH, 64, time counter width
- NUMERATOR, 10, clock-period numerator; NUMERATOR >= DENOMINATOR is enforced by an elaboration assertion
- DENOMINATOR, 3, clock-period denominator, >= 1
- CHANNELS, 4, number of trigger channels and number of capture channels, 1..32

Ports:
- reset  in  1  asynchronous, active-high
- clk  in  1  single clock for all logic
- set_time  in  TIMER_WIDTH  time to load
- set_valid  in  1  load request
- adjust_sign  in  1  0 = +1, 1 = -1
- adjust_valid  in  1  adjust request
- adjust_ready  out  1  adjust accepted when valid & ready
- current_time  out  TIMER_WIDTH  registered time
- trig_time  in  CHANNELS*TIMER_WIDTH  per-channel target; channel i at [i*TIMER_WIDTH +: TIMER_WIDTH]
- trig_period  in  CHANNELS*TIMER_WIDTH  per-channel period; 0 = one-shot
- trig_valid  in  CHANNELS  arm and load target/period
- trig_cancel  in  CHANNELS  disarm
- trig_armed  out  CHANNELS  channel armed
- trig_pulse  out  CHANNELS  one-cycle fire pulse
- cap_in  in  CHANNELS  synchronous capture inputs
- cap_time  out  CHANNELS*TIMER_WIDTH  captured time
- cap_valid  out  CHANNELS  one-cycle pulse; cap_time is valid in the same cycle

## Operation
- Constants:
  - INT = NUMERATOR / DENOMINATOR
  - FRAC = NUMERATOR % DENOMINATOR
- Fractional step, evaluated every cycle:
  - acc_sum = acc + FRAC
  - carry = (acc_sum >= DENOMINATOR)
  - acc <= carry ? acc_sum - DENOMINATOR : acc_sum
  - acc width is clog2(DENOMINATOR) + 1
- Step = INT + carry + adj, where adj ∈ {+1, -1, 0} comes from the pending adjust. Step may be 0 and is never negative.
- current_time <= current_time + step, modulo 2^TIMER_WIDTH (wraps silently).
- Adjust handling:
  - adjust_ready = !pending.
  - On valid & ready: pending <= 1 and sign is latched.
  - The following edge applies adj and clears pending.
  - Maximum rate is one adjust per 2 cycles.
- Set handling: set_valid has priority over stepping. On set_valid:
  - current_time <= set_time
  - acc <= 0
  - pending <= 0; a latched adjust is discarded
  - An adjust handshake completing in the same cycle is also discarded.
- Trigger channel i:
  - trig_valid[i]: target <= trig_time, period <= trig_period, armed <= 1.
  - trig_cancel[i]: armed <= 0. Cancel wins over a simultaneous valid.
  - Fire condition: armed & MSB(current_time - target) == 0, i.e. a wrap-safe signed compare (current_time >= target).
  - On fire with period == 0: armed <= 0.
  - On fire with period != 0: target <= target + period (modulo) and the channel stays armed.
  - Catch-up: a target still in the past fires again on the next cycle, one pulse per cycle. No fires are skipped.
  - A fire in the same cycle as trig_valid is overridden: the new load wins and no pulse is emitted.
  - A set_valid that moves time past the target causes a normal fire on the next evaluation.
- Capture channel i:
  - prev[i] <= cap_in[i].
  - On cap_in & !prev: cap_time[i] <= current_time and cap_valid[i] <= 1 (registered). Otherwise cap_valid[i] <= 0.
  - cap_time[i] holds its value until the next capture.

## Timing
- Reset values:
  - current_time 0, acc 0, pending 0, so adjust_ready = 1
  - trig_armed 0, trig_pulse 0, target 0, period 0
  - cap_time 0, cap_valid 0
  - prev all 1, so an input that is already high at reset release does not capture
- Reset mid-operation returns all state to these values asynchronously.
- Set: set_valid at edge k → current_time = set_time after edge k. The step resumes at edge k+1.
- Adjust: accepted at edge k → adjust_ready low for one cycle → adj included in the step at edge k+1.
- Trigger:
  - Armed at edge k → compare first evaluated on current_time after edge k → pulse registered at edge k+1.
  - trig_pulse is asserted in the cycle after current_time first satisfies the compare.
  - trig_armed falls in the same cycle as the one-shot pulse.
- Capture: cap_time equals the current_time of the cycle in which cap_in is first high. cap_valid is high for the next cycle.
- All outputs are registered except adjust_ready.

## Test plan
- Step: NUMERATOR = 10, DENOMINATOR = 3, release reset, no other stimulus → current_time sequence 3, 6, 10, 13, 16, 20; 300 cycles → exactly 1000.
- Adjust interplay:
  - Adjust -1 accepted at time 10 → next value 12 instead of 13; adjust_ready low exactly one cycle.
  - Back-to-back adjust_valid → accepted every other cycle.
  - set_valid with set_time = 500 together with a pending adjust → 500, then 503; adjust discarded.
- One-shot: arm ch0 with target 100, period 0 → single trig_pulse[0] the cycle after current_time first ≥ 100; armed drops with it.
- Periodic/wrap:
  - Arm ch1 with target 2^64-5, period 20, starting near wrap → pulses every 6 cycles (20 time units per 6 cycles = 3 steps of 10/3 twice) with wrap-safe compare.
  - Cancel with simultaneous valid → disarmed, no pulse.
- Capture: cap_in[2] rises when current_time = 40 → cap_time[2] = 40 and cap_valid[2] pulses once. A held-high input does not recapture. Input high during reset → no capture.
- Catch-up: arm ch3 with target 0, period 1 at time 1000 → trig_pulse[3] every cycle; target advances by 1 per cycle while time advances by at least 3, so the channel never catches up and does not stall.
